// File: rtl/clock_adjust_pkg.sv
// Shared constants for the clock-adjust link. The generator and the decoder both take their
// defaults from here, so the pulse geometry is defined in one place.
//   LOW_LEN_DEF   : low-phase width in CLK cycles
//   STEP_DEF      : high-phase quantum; high width = STEP*(level+1)
//   MAX_LEVEL_DEF : largest legal level
//   CNT_W_DEF     : phase counter width (saturates at all-ones)
//   LEVEL_W       : width of the level field
package clock_adjust_pkg;

  localparam int unsigned LOW_LEN_DEF   = 30;
  localparam int unsigned STEP_DEF      = 11;
  localparam int unsigned MAX_LEVEL_DEF = 7;
  localparam int unsigned CNT_W_DEF     = 7;
  localparam int unsigned LEVEL_W       = 3;

endpackage

// File: rtl/clock_level_decoder_if.sv
// Pulse-stream input and decoded-level outputs of the clock level decoder.
//   PULSE       : incoming pulse stream, synchronous to CLK
//   LEVEL       : last decoded level
//   LEVEL_VALID : one-cycle strobe, LEVEL updated this cycle
//   LOCKED      : at least one good decode since last error/reset
//   ERR         : one-cycle strobe on a malformed phase
// master = stream source / output consumer, slave = decoder.
interface clock_level_decoder_if;
  import clock_adjust_pkg::*;

  logic               PULSE;
  logic [LEVEL_W-1:0] LEVEL;
  logic               LEVEL_VALID;
  logic               LOCKED;
  logic               ERR;

  modport master (output PULSE, input LEVEL, input LEVEL_VALID, input LOCKED, input ERR);
  modport slave  (input PULSE, output LEVEL, output LEVEL_VALID, output LOCKED, output ERR);

endinterface

// File: rtl/pulse_width_classifier.sv
// Combinational classifier for a measured high-phase width.
//   w     : measured width in CLK cycles
//   k     : level whose width STEP*(k+1) equals w (0 when not legal)
//   legal : w matches one of STEP*1 .. STEP*(MAX_LEVEL+1)
// Uses a bank of constant comparisons instead of a divider.
module pulse_width_classifier
  import clock_adjust_pkg::*;
#(
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned MAX_LEVEL = MAX_LEVEL_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic [CNT_W-1:0]   w,
  output logic [LEVEL_W-1:0] k,
  output logic               legal
);

  always_comb begin
    k     = '0;
    legal = 1'b0;
    for (int unsigned i = 0; i <= MAX_LEVEL; i++) begin
      if (32'(w) == STEP * (i + 1)) begin
        k     = LEVEL_W'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_level_decoder.sv
// Receive-side decoder for the variable-width clock pulse stream. Measures every high and low
// phase on CLK, recovers the level encoded in the high width and flags malformed phases.
//   CLK : system clock, all logic on posedge
//   RST : synchronous, active-high reset
//   bus : clock_level_decoder_if.slave (PULSE in; LEVEL, LEVEL_VALID, LOCKED, ERR out)
// Optional feature: define CLKDEC_LOW_CHECK_EN to also require each measured low phase to be
// exactly LOW_LEN cycles wide.
module clock_level_decoder
  import clock_adjust_pkg::*;
#(
  parameter int unsigned LOW_LEN   = LOW_LEN_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned MAX_LEVEL = MAX_LEVEL_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input logic                  CLK,
  input logic                  RST,
  clock_level_decoder_if.slave bus
);

`ifdef CLKDEC_LOW_CHECK_EN
  localparam bit LowCheckEn = 1'b1;
`else
  localparam bit LowCheckEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LowLenW = CNT_W'(LOW_LEN);

  typedef enum logic [1:0] {StSync, StFirstLow, StHigh, StLow} state_e;

  state_e             state_q, state_d;
  logic               p_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               level_valid_q, level_valid_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;

  logic               rise, fall, cnt_sat;
  logic [LEVEL_W-1:0] cls_level;
  logic               cls_legal;

  assign rise    = bus.PULSE & ~p_q;
  assign fall    = ~bus.PULSE & p_q;
  assign cnt_sat = (cnt_q == CntMax);

  // At an edge the counter still holds the full width of the phase that just ended.
  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall) begin
      cnt_d = CNT_W'(1);
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  pulse_width_classifier #(
    .STEP      (STEP),
    .MAX_LEVEL (MAX_LEVEL),
    .CNT_W     (CNT_W)
  ) u_classifier (
    .w     (cnt_q),
    .k     (cls_level),
    .legal (cls_legal)
  );

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    locked_d      = locked_q;
    err_d         = 1'b0;
    unique case (state_q)
      // The phase in progress at reset is partial, so wait for a clean low.
      StSync: begin
        if (!bus.PULSE) state_d = StFirstLow;
      end
      StFirstLow: begin
        if (rise) state_d = StHigh;
      end
      StHigh: begin
        if (fall) begin
          state_d = StLow;
          if (cls_legal) begin
            level_d       = cls_level;
            level_valid_d = 1'b1;
            locked_d      = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
        end else if (cnt_sat) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = StSync;
        end
      end
      StLow: begin
        if (rise) begin
          // Enter HIGH regardless so a bad low width does not cost alignment.
          state_d = StHigh;
          if (LowCheckEn && (cnt_q != LowLenW)) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
        end else if (cnt_sat) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = StSync;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StSync;
      p_q           <= 1'b0;
      cnt_q         <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= bus.PULSE;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign bus.LEVEL       = level_q;
  assign bus.LEVEL_VALID = level_valid_q;
  assign bus.LOCKED      = locked_q;
  assign bus.ERR         = err_q;

endmodule

// File: tb/tb_clock_level_decoder.sv
// Self-checking bench for clock_level_decoder. Stimulus is a list of phases (value, length);
// the reference model reasons per phase: which phases the decoder can measure, what each
// measured phase should produce, and when a stuck phase hits the counter ceiling.
module tb_clock_level_decoder;

`ifdef CLKDEC_LOW_CHECK_EN
  localparam bit LowChk = 1'b1;
`else
  localparam bit LowChk = 1'b0;
`endif

  localparam int LowLen   = 30;
  localparam int Step     = 11;
  localparam int MaxLevel = 7;
  localparam int SatIdx   = 127;  // cycle within a stuck phase where the ceiling is reached

  logic CLK = 1'b0;
  logic RST = 1'b1;

  clock_level_decoder_if bus ();

  clock_level_decoder dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [2:0] m_level;
  bit         m_locked;
  bit         seen_low;      // a low has been observed since the last resync
  logic       prev_v;
  int         prev_len;
  bit         prev_tracked;  // previous phase was being measured

  task automatic do_reset(input logic pv);
    RST       = 1'b1;
    bus.PULSE = pv;
    @(posedge CLK); #1;
    n_total++; if (bus.LEVEL !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.LEVEL);
    else n_pass++;
    n_total++; if (bus.LEVEL_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0",
                                                     bus.LEVEL_VALID);
    else n_pass++;
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL reset_locked: got %b want 0", bus.LOCKED);
    else n_pass++;
    n_total++; if (bus.ERR !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.ERR);
    else n_pass++;
    @(posedge CLK); #1;
    RST          = 1'b0;
    m_level      = 3'd0;
    m_locked     = 1'b0;
    seen_low     = (pv == 1'b0);
    prev_v       = pv;
    prev_len     = 0;
    prev_tracked = 1'b0;
  endtask

  // Drive one phase and check every cycle of it against the model.
  task automatic drive_phase(input logic v, input int len);
    bit         ev_valid = 1'b0;
    bit         ev_err   = 1'b0;
    logic [2:0] ev_level = 3'd0;
    bit         tracked;
    bit         exp_valid, exp_err;
    if (v != prev_v && prev_tracked) begin
      if (prev_v) begin
        if (prev_len % Step == 0 && prev_len / Step >= 1 && prev_len / Step <= MaxLevel + 1) begin
          ev_valid = 1'b1;
          ev_level = 3'(prev_len / Step - 1);
        end else begin
          ev_err = 1'b1;
        end
      end else if (LowChk && prev_len != LowLen) begin
        ev_err = 1'b1;
      end
    end
    if (v) begin
      tracked = seen_low;
    end else begin
      tracked  = (v != prev_v) && prev_v && prev_tracked;
      seen_low = 1'b1;
    end
    bus.PULSE = v;
    for (int j = 0; j < len; j++) begin
      @(posedge CLK); #1;
      exp_valid = (j == 0) && ev_valid;
      exp_err   = (j == 0) && ev_err;
      if (exp_valid) begin
        m_level  = ev_level;
        m_locked = 1'b1;
      end
      if (exp_err) m_locked = 1'b0;
      if (tracked && j == SatIdx) begin
        exp_err  = 1'b1;
        m_locked = 1'b0;
        tracked  = 1'b0;
        if (v) seen_low = 1'b0;
      end
      n_total++;
      if (bus.LEVEL_VALID !== exp_valid)
        $display("FAIL level_valid @%0t (phase %b len %0d cyc %0d): got %b want %b",
                 $time, v, len, j, bus.LEVEL_VALID, exp_valid);
      else n_pass++;
      n_total++;
      if (bus.ERR !== exp_err)
        $display("FAIL err @%0t (phase %b len %0d cyc %0d): got %b want %b",
                 $time, v, len, j, bus.ERR, exp_err);
      else n_pass++;
      n_total++;
      if (bus.LEVEL !== m_level)
        $display("FAIL level @%0t: got %0d want %0d", $time, bus.LEVEL, m_level);
      else n_pass++;
      n_total++;
      if (bus.LOCKED !== m_locked)
        $display("FAIL locked @%0t: got %b want %b", $time, bus.LOCKED, m_locked);
      else n_pass++;
    end
    prev_v       = v;
    prev_len     = len;
    prev_tracked = tracked;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
  endtask

  task automatic test_level3();
    drive_phase(1'b0, LowLen);
    for (int i = 0; i < 3; i++) begin
      drive_phase(1'b1, 44);
      drive_phase(1'b0, LowLen);
    end
    n_total++; if (bus.LEVEL !== 3'd3) $display("FAIL level3_final: got %0d want 3", bus.LEVEL);
    else n_pass++;
    n_total++; if (bus.LOCKED !== 1'b1) $display("FAIL level3_locked: got %b want 1", bus.LOCKED);
    else n_pass++;
  endtask

  task automatic test_sweep();
    for (int l = 0; l <= MaxLevel; l++) begin
      drive_phase(1'b1, Step * (l + 1));
      drive_phase(1'b0, LowLen);
    end
    n_total++; if (bus.LEVEL !== 3'd7) $display("FAIL sweep_final: got %0d want 7", bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_bad_high();
    drive_phase(1'b1, 44);
    drive_phase(1'b0, LowLen);
    drive_phase(1'b1, 45);
    drive_phase(1'b0, LowLen);
    n_total++; if (bus.LOCKED !== 1'b0) $display("FAIL bad_high_locked: got %b want 0", bus.LOCKED);
    else n_pass++;
    n_total++; if (bus.LEVEL !== 3'd3) $display("FAIL bad_high_hold: got %0d want 3", bus.LEVEL);
    else n_pass++;
    drive_phase(1'b1, 44);
    drive_phase(1'b0, LowLen);
  endtask

  task automatic test_low_short();
    drive_phase(1'b1, 44);
    drive_phase(1'b0, 29);
    drive_phase(1'b1, 22);
    drive_phase(1'b0, LowLen);
    n_total++; if (bus.LEVEL !== 3'd1) $display("FAIL low_short_level: got %0d want 1", bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_stuck();
    drive_phase(1'b1, 44);
    drive_phase(1'b0, LowLen);
    drive_phase(1'b1, 200);
    drive_phase(1'b0, LowLen);
    drive_phase(1'b1, 66);
    drive_phase(1'b0, LowLen);
    drive_phase(1'b1, 44);
    drive_phase(1'b0, LowLen);
    n_total++; if (bus.LOCKED !== 1'b1) $display("FAIL stuck_relock: got %b want 1", bus.LOCKED);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_phase(1'b1, 20);
    do_reset(1'b1);
    drive_phase(1'b1, 24);
    drive_phase(1'b0, LowLen);
    drive_phase(1'b1, 44);
    drive_phase(1'b0, LowLen);
    n_total++; if (bus.LEVEL !== 3'd3) $display("FAIL reset_mid_level: got %0d want 3", bus.LEVEL);
    else n_pass++;
  endtask

  task automatic test_random();
    int hl, ll;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(99) < 5) hl = 130 + int'($urandom_range(30));
      else if ($urandom_range(99) < 70) hl = Step * (1 + int'($urandom_range(MaxLevel)));
      else hl = 3 + int'($urandom_range(97));
      if ($urandom_range(99) < 5) ll = 130 + int'($urandom_range(20));
      else if ($urandom_range(99) < 70) ll = LowLen;
      else ll = 5 + int'($urandom_range(55));
      drive_phase(1'b1, hl);
      drive_phase(1'b0, ll);
    end
  endtask

  initial begin
    bus.PULSE = 1'b0;
    test_reset();
    test_level3();
    test_sweep();
    test_bad_high();
    test_low_short();
    test_stuck();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
